hv_gen_ctrl: RTL and testbench

HV_GEN_CTRL -- requirements
Module: hv_gen_ctrl

---
 rtl/hv_gen_ctrl.sv | 143 ++++++++++++++
 tb/tb_hv_gen_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hv_gen_ctrl.sv
// Hypervector generator: produces the seed advanced by req_idx CA90 steps.
// Steps forward from the last delivered index where possible, otherwise restarts from the seed.
`ifndef DIM
`define DIM 8
`endif

module hv_gen_ctrl #(
  parameter int unsigned DIM   = `DIM,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [DIM-1:0]   seed_in,
  input  logic             req_valid,
  input  logic [IDX_W-1:0] req_idx,
  output logic             req_ready,
  output logic             hv_valid,
  output logic [DIM-1:0]   hv_out,
  input  logic             hv_ready,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StRestore, StStep, StDone} state_e;

  state_e           state_q, state_d;
  logic [DIM-1:0]   seed_q, seed_d;
  logic [DIM-1:0]   cur_v_q, cur_v_d;
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic [IDX_W-1:0] tgt_idx_q, tgt_idx_d;
  logic [DIM-1:0]   hv_out_q, hv_out_d;
  logic             hv_valid_q, hv_valid_d;

  logic [DIM-1:0]   ca90_v;
  logic [IDX_W-1:0] idx_inc;
  logic             req_accept;
  logic             hv_accept;

  // Rule 90: each cell becomes the XOR of its two cyclic neighbours.
  assign ca90_v     = {cur_v_q[DIM-2:0], cur_v_q[DIM-1]} ^ {cur_v_q[0], cur_v_q[DIM-1:1]};
  assign idx_inc    = cur_idx_q + 1'b1;
  assign req_accept = req_valid & req_ready;
  assign hv_accept  = hv_valid_q & hv_ready;

  // State register and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      seed_q     <= '0;
      cur_v_q    <= '0;
      cur_idx_q  <= '0;
      tgt_idx_q  <= '0;
      hv_out_q   <= '0;
      hv_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seed_q     <= seed_d;
      cur_v_q    <= cur_v_d;
      cur_idx_q  <= cur_idx_d;
      tgt_idx_q  <= tgt_idx_d;
      hv_out_q   <= hv_out_d;
      hv_valid_q <= hv_valid_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_accept) begin
          if (req_idx == cur_idx_q) begin
            state_d = StDone;
          end else if (req_idx > cur_idx_q) begin
            state_d = StStep;
          end else begin
            state_d = StRestore;
          end
        end
      end
      StRestore: state_d = (tgt_idx_q != '0) ? StStep : StDone;
      StStep: begin
        if (idx_inc == tgt_idx_q) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (hv_accept) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state logic.
  always_comb begin
    seed_d     = seed_q;
    cur_v_d    = cur_v_q;
    cur_idx_d  = cur_idx_q;
    tgt_idx_d  = tgt_idx_q;
    hv_out_d   = hv_out_q;
    hv_valid_d = hv_valid_q;
    unique case (state_q)
      StIdle: begin
        if (seed_load) begin
          seed_d    = seed_in;
          cur_v_d   = seed_in;
          cur_idx_d = '0;
        end else if (req_accept) begin
          tgt_idx_d = req_idx;
        end
      end
      StRestore: begin
        cur_v_d   = seed_q;
        cur_idx_d = '0;
      end
      StStep: begin
        cur_v_d   = ca90_v;
        cur_idx_d = idx_inc;
      end
      StDone: begin
        // First DONE cycle captures the result; it then holds until the consumer takes it.
        if (!hv_valid_q) begin
          hv_out_d   = cur_v_q;
          hv_valid_d = 1'b1;
        end else if (hv_ready) begin
          hv_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output logic.
  always_comb begin
    req_ready = (state_q == StIdle) & ~seed_load;
    busy      = (state_q != StIdle);
    hv_valid  = hv_valid_q;
    hv_out    = hv_out_q;
  end

endmodule

// File: tb/tb_hv_gen_ctrl.sv
// Directed bench for hv_gen_ctrl at DIM=8, IDX_W=8 with hand-computed CA90 results.
module tb_hv_gen_ctrl;

  logic       clk;
  logic       rst;
  logic       seed_load;
  logic [7:0] seed_in;
  logic       req_valid;
  logic [7:0] req_idx;
  logic       req_ready;
  logic       hv_valid;
  logic [7:0] hv_out;
  logic       hv_ready;
  logic       busy;

  int n_cmp;
  int n_bad;

  hv_gen_ctrl #(
    .DIM  (8),
    .IDX_W(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .seed_load(seed_load),
    .seed_in  (seed_in),
    .req_valid(req_valid),
    .req_idx  (req_idx),
    .req_ready(req_ready),
    .hv_valid (hv_valid),
    .hv_out   (hv_out),
    .hv_ready (hv_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, check it is accepted on the next edge.
  task automatic do_req(input logic [7:0] idx);
    req_valid = 1'b1;
    req_idx   = idx;
    #1;
    check_eq("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    check_eq("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  // Count edges after acceptance until hv_valid rises; bounded.
  task automatic wait_hv(output int n);
    n = 0;
    while (!hv_valid && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic handshake();
    hv_ready = 1'b1;
    tick();
    hv_ready = 1'b0;
    check_eq("hv_valid_after_hs", {31'd0, hv_valid}, 32'd0);
    check_eq("busy_after_hs", {31'd0, busy}, 32'd0);
    check_eq("req_ready_after_hs", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int seen;
    logic [7:0] fwd_exp [3];
    fwd_exp[0] = 8'h82;
    fwd_exp[1] = 8'h44;
    fwd_exp[2] = 8'hAA;
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    seed_load = 1'b0;
    seed_in   = 8'h00;
    req_valid = 1'b0;
    req_idx   = 8'h00;
    hv_ready  = 1'b0;

    // Reset state
    #1;
    check_eq("rst_hv_valid", {31'd0, hv_valid}, 32'd0);
    check_eq("rst_hv_out", {24'd0, hv_out}, 32'h00);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Load seed 0x01, request index 0
    seed_load = 1'b1;
    seed_in   = 8'h01;
    #1;
    check_eq("req_ready_during_seed", {31'd0, req_ready}, 32'd0);
    tick();
    seed_load = 1'b0;
    do_req(8'd0);
    wait_hv(lat);
    check_eq("idx0_latency", lat, 32'd1);
    check_eq("idx0_hv_out", {24'd0, hv_out}, 32'h01);
    handshake();

    // Forward to index 3, observing each step
    do_req(8'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("fwd_cur_v", {24'd0, dut.cur_v_q}, {24'd0, fwd_exp[i]});
      check_eq("fwd_no_valid_yet", {31'd0, hv_valid}, 32'd0);
    end
    tick();
    check_eq("fwd_hv_valid", {31'd0, hv_valid}, 32'd1);
    check_eq("fwd_hv_out", {24'd0, hv_out}, 32'hAA);

    // Backpressure: outputs held while hv_ready low
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_hv_valid", {31'd0, hv_valid}, 32'd1);
      check_eq("bp_hv_out", {24'd0, hv_out}, 32'hAA);
      check_eq("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    handshake();

    // Backward to index 1: restore then one step
    do_req(8'd1);
    wait_hv(lat);
    check_eq("bwd_latency", lat, 32'd3);
    check_eq("bwd_hv_out", {24'd0, hv_out}, 32'h82);
    handshake();

    // Collision: seed_load wins over a request in IDLE
    seed_load = 1'b1;
    seed_in   = 8'h10;
    req_valid = 1'b1;
    req_idx   = 8'd0;
    #1;
    check_eq("coll_req_ready", {31'd0, req_ready}, 32'd0);
    tick();
    seed_load = 1'b0;
    check_eq("coll_not_accepted", {31'd0, busy}, 32'd0);
    do_req(8'd0);
    wait_hv(lat);
    check_eq("coll_latency", lat, 32'd1);
    check_eq("coll_hv_out", {24'd0, hv_out}, 32'h10);
    handshake();

    // Reset in the middle of a long forward walk
    do_req(8'd200);
    for (int i = 0; i < 5; i++) tick();
    check_eq("mid_busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("mid_rst_hv_out", {24'd0, hv_out}, 32'h00);
    tick();
    rst = 1'b0;
    check_eq("mid_rst_cur_idx", {24'd0, dut.cur_idx_q}, 32'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (hv_valid) seen++;
    end
    check_eq("mid_rst_no_valid", seen, 32'd0);
    do_req(8'd0);
    wait_hv(lat);
    check_eq("post_rst_latency", lat, 32'd1);
    check_eq("post_rst_hv_out", {24'd0, hv_out}, 32'h00);
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
